// File: rtl/coin_change_dispenser.sv
// Greedy four-channel coin change dispenser with per-tube inventory.
// Moore FSM: one SEL gap cycle precedes every COIN pulse cycle.
module coin_change_dispenser #(
  parameter int W          = 7,
  parameter int V_Q        = 25,
  parameter int V_D        = 10,
  parameter int V_N        = 5,
  parameter int V_P        = 1,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] money,
  input  logic [W-1:0] price,
  input  logic         refill,
  output logic         disp_Q,
  output logic         disp_D,
  output logic         disp_N,
  output logic         disp_P,
  output logic         done,
  output logic         busy,
  output logic         underpaid,
  output logic         short_change,
  output logic [W-1:0] change_left,
  output logic [3:0]   stock_empty
);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    COIN,
    DONE
  } state_t;

  localparam logic [3:0][W-1:0] VAL = {
    W'(V_Q), W'(V_D), W'(V_N), W'(V_P)
  };
  localparam logic [STOCK_W-1:0] INIT =
    STOCK_W'(STOCK_INIT);

  state_t                   state_q, state_d;
  logic [W-1:0]             change_q, change_d;
  logic [1:0]               sel_q, sel_d;
  logic                     up_q, up_d;
  logic                     short_q, short_d;
  logic [3:0][STOCK_W-1:0]  stock_q, stock_d;

  logic                     pick_ok;
  logic [1:0]               pick;

  // Highest-value channel that fits the remainder and has stock.
  always_comb begin
    pick_ok = 1'b0;
    pick    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (change_q >= VAL[i] && stock_q[i] != '0) begin
        pick_ok = 1'b1;
        pick    = 2'(i);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    sel_d    = sel_q;
    up_d     = up_q;
    short_d  = short_q;
    stock_d  = stock_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (refill) begin
          stock_d = {4{INIT}};
        end
        if (start) begin
          change_d = (money >= price) ?
                     money - price : money;
          up_d     = (money < price);
          short_d  = 1'b0;
          state_d  = SEL;
        end
      end
      SEL: begin
        if (change_q == '0) begin
          state_d = DONE;
        end else if (pick_ok) begin
          sel_d         = pick;
          change_d      = change_q - VAL[pick];
          stock_d[pick] = stock_q[pick] -
                          STOCK_W'(1);
          state_d       = COIN;
        end else begin
          short_d = 1'b1;
          state_d = DONE;
        end
      end
      COIN: begin
        state_d = SEL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      change_q <= '0;
      sel_q    <= 2'd0;
      up_q     <= 1'b0;
      short_q  <= 1'b0;
      stock_q  <= {4{INIT}};
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
      sel_q    <= sel_d;
      up_q     <= up_d;
      short_q  <= short_d;
      stock_q  <= stock_d;
    end
  end

  // Empty-tube flags straight from the counters.
  always_comb begin
    stock_empty = '0;
    for (int i = 0; i < 4; i++) begin
      stock_empty[i] = (stock_q[i] == '0);
    end
  end

  assign disp_Q = (state_q == COIN) && (sel_q == 2'd3);
  assign disp_D = (state_q == COIN) && (sel_q == 2'd2);
  assign disp_N = (state_q == COIN) && (sel_q == 2'd1);
  assign disp_P = (state_q == COIN) && (sel_q == 2'd0);

  assign done         = (state_q == DONE);
  assign busy         = (state_q == SEL) ||
                        (state_q == COIN);
  assign underpaid    = up_q;
  assign short_change = short_q;
  assign change_left  = change_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser.
// Vector table plus a mid-transaction reset sequence.
module tb_coin_change_dispenser;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         refill = 1'b0;
  logic [W-1:0] money = '0;
  logic [W-1:0] price = '0;
  logic         disp_Q, disp_D, disp_N, disp_P;
  logic         done, busy, underpaid, short_change;
  logic [W-1:0] change_left;
  logic [3:0]   stock_empty;

  int n_cmp = 0;
  int n_bad = 0;

  coin_change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .money        (money),
    .price        (price),
    .refill       (refill),
    .disp_Q       (disp_Q),
    .disp_D       (disp_D),
    .disp_N       (disp_N),
    .disp_P       (disp_P),
    .done         (done),
    .busy         (busy),
    .underpaid    (underpaid),
    .short_change (short_change),
    .change_left  (change_left),
    .stock_empty  (stock_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         rf;
    logic         noise;
    logic [W-1:0] money;
    logic [W-1:0] price;
    logic [31:0]  seq;
    int           n;
    int           done_k;
    logic         up;
    logic         sh;
    logic [W-1:0] left;
    logic [3:0]   empty;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rf,
                     input logic noise,
                     input int m, input int p,
                     input logic [31:0] seq, input int n,
                     input int dk, input logic up,
                     input logic sh, input int left,
                     input logic [3:0] empty);
    vec_t v;
    v.rst = rst; v.rf = rf; v.noise = noise;
    v.money = W'(m); v.price = W'(p);
    v.seq = seq; v.n = n; v.done_k = dk;
    v.up = up; v.sh = sh; v.left = W'(left);
    v.empty = empty;
    vq.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_disp"},
          {disp_Q, disp_D, disp_N, disp_P}, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_up"}, underpaid, 0);
    check({tag, "_short"}, short_change, 0);
    check({tag, "_left"}, change_left, 0);
    check({tag, "_empty"}, stock_empty, 0);
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b0;
    #2;
    check_idle("reset");
    tick;
    reset = 1'b1;
  endtask

  task automatic run(input vec_t v, input int idx);
    logic [31:0] seq;
    logic [3:0]  d;
    logic [3:0]  code;
    int          cnt, done_k, busy_bad, tim_bad;
    string       t;
    t = $sformatf("v%0d", idx);
    if (v.rst) do_reset;
    money  = v.money;
    price  = v.price;
    start  = 1'b1;
    refill = v.rf;
    tick;
    if (v.noise) begin
      start  = 1'b1;
      refill = 1'b1;
      money  = 7'd7;
      price  = 7'd0;
    end else begin
      start  = 1'b0;
      refill = 1'b0;
    end
    seq = '0; cnt = 0; done_k = 0;
    busy_bad = 0; tim_bad = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      if (k > 1) tick;
      d = {disp_Q, disp_D, disp_N, disp_P};
      if (done) begin
        done_k = k;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      if (d != 4'd0) begin
        if (k != 2 * cnt + 2 || $countones(d) != 1)
          tim_bad++;
        code = disp_Q ? 4'd4 : disp_D ? 4'd3 :
               disp_N ? 4'd2 : 4'd1;
        seq = {seq[27:0], code};
        cnt++;
      end
    end
    start  = 1'b0;
    refill = 1'b0;
    check({t, "_done_cycle"}, done_k, v.done_k);
    check({t, "_coins"}, cnt, v.n);
    check({t, "_seq"}, seq, v.seq);
    check({t, "_pulse_timing"}, tim_bad, 0);
    check({t, "_busy"}, busy_bad, 0);
    check({t, "_underpaid"}, underpaid, v.up);
    check({t, "_short"}, short_change, v.sh);
    check({t, "_left"}, change_left, v.left);
    check({t, "_empty"}, stock_empty, v.empty);
  endtask

  initial begin
    add(1, 0, 0, 41, 0, 'h4321, 4, 10, 0, 0, 0, 0);
    add(0, 0, 0, 30, 30, 0, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 12, 50, 'h311, 3, 8, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(i == 0, 0, 0, 25, 0, 'h4, 1, 4, 0, 0, 0,
          (i == 7) ? 4'b1000 : 4'b0000);
    add(0, 0, 0, 30, 0, 'h333, 3, 8, 0, 0, 0, 4'b1000);
    for (int i = 0; i < 8; i++)
      add(i == 0, 0, 0, 1, 0, 'h1, 1, 4, 0, 0, 0,
          (i == 7) ? 4'b0001 : 4'b0000);
    add(0, 0, 0, 3, 0, 0, 0, 2, 0, 1, 3, 4'b0001);
    add(0, 1, 0, 3, 0, 'h111, 3, 8, 0, 0, 0, 0);
    add(0, 0, 0, 68, 10, 'h442111, 6, 14, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5, 0, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(i == 0, 0, 0, 25, 0, 'h4, 1, 4, 0, 0, 0, 0);
    add(0, 0, 1, 50, 0, 'h4332, 4, 10, 0, 0, 0,
        4'b1000);

    reset = 1'b0;
    #12;
    reset = 1'b1;

    foreach (vq[i]) run(vq[i], i);

    do_reset;
    money = 7'd99;
    price = 7'd0;
    start = 1'b1;
    tick;
    start  = 1'b1;
    refill = 1'b1;
    money  = 7'd5;
    check("mr_k1_busy", busy, 1);
    check("mr_k1_left", change_left, 99);
    tick;
    check("mr_k2_disp",
          {disp_Q, disp_D, disp_N, disp_P}, 4'b1000);
    check("mr_k2_left", change_left, 74);
    tick;
    check("mr_k3_disp",
          {disp_Q, disp_D, disp_N, disp_P}, 4'b0000);
    check("mr_k3_left", change_left, 74);
    tick;
    check("mr_k4_disp",
          {disp_Q, disp_D, disp_N, disp_P}, 4'b1000);
    check("mr_k4_left", change_left, 49);
    tick;
    reset  = 1'b0;
    start  = 1'b0;
    refill = 1'b0;
    #2;
    check_idle("mr_async");
    tick;
    tick;
    check_idle("mr_held");
    reset = 1'b1;
    begin
      vec_t v;
      v.rst = 0; v.rf = 0; v.noise = 0;
      v.money = 7'd25; v.price = 7'd0;
      v.seq = 'h4; v.n = 1; v.done_k = 4;
      v.up = 0; v.sh = 0; v.left = '0;
      v.empty = 4'b0000;
      run(v, 99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
